// File: rtl/bch_t8_pkg.sv
// Shared constants and types for the DVB-S2 t=8 BCH parity engine.
package bch_t8_pkg;

    localparam int BCH_W        = 16;
    localparam int BCH_PAR_BITS = 128;
    localparam int PAR_WORDS    = 8;
    localparam int ROM_ROWS     = 16;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_DATA   = 2'd2,
        ST_PARITY = 2'd3
    } fsm_state_e;

    // One 128-bit next-state contribution per bit of the 16-bit feedback word.
    typedef logic [ROM_ROWS-1:0][BCH_PAR_BITS-1:0] row_bank_t;

endpackage

// File: rtl/bch_t8_lfsr_step.sv
// One 16-bit-parallel step of the 128-bit BCH remainder register.
module bch_t8_lfsr_step
    import bch_t8_pkg::*;
(
    input  logic [BCH_PAR_BITS-1:0] state,
    input  logic [BCH_W-1:0]        data,
    input  row_bank_t               bank,
    output logic [BCH_PAR_BITS-1:0] next_state
);

    logic [BCH_W-1:0] f;

    // NOTE: blocking assignments are correct here; the XOR tree is built by
    // accumulating into next_state in order, and every output gets a default first.
    always_comb begin
        f          = state[BCH_PAR_BITS-1 -: BCH_W] ^ data;
        next_state = {state[BCH_PAR_BITS-BCH_W-1:0], {BCH_W{1'b0}}};
        for (int k = 0; k < BCH_W; k++) begin
            if (f[k]) begin
                next_state = next_state ^ bank[k];
            end
        end
    end

endmodule

// File: rtl/bch_t8_parity_engine.sv
// Systematic BCH (t=8) parity appender, 16 bits per clock, with ROM preload.
// Optional build macro BCH_BYPASS_EN adds a per-frame parity bypass input.
module bch_t8_parity_engine
    import bch_t8_pkg::*;
#(
    parameter int ROW_CNT   = 16,
    parameter int PAR_WORDS = 8
) (
    input  logic         clk_1x,
    input  logic         rst_n,
    output logic         rom_rd_en,
    output logic [4:0]   rom_rdaddr,
    input  logic [127:0] rom_rd_q,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [15:0]  s_data,
    input  logic         s_last,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [15:0]  m_data,
    output logic         m_last,
    output logic         busy_load
`ifdef BCH_BYPASS_EN
    ,
    input  logic         bch_bypass
`endif
);

    localparam int PCW = (PAR_WORDS > 1) ? $clog2(PAR_WORDS) : 1;
    localparam logic [PCW-1:0] PAR_LAST   = PCW'(PAR_WORDS - 1);
    localparam logic [4:0]     LOAD_ISSUE = 5'(ROW_CNT);
    localparam logic [4:0]     LOAD_DONE  = 5'(ROW_CNT + 1);

    fsm_state_e              fsm;
    logic [4:0]              load_cnt;
    logic                    cap_en;
    logic [3:0]              cap_addr;
    row_bank_t               bank;
    logic [BCH_PAR_BITS-1:0] lfsr;
    logic [BCH_PAR_BITS-1:0] lfsr_next;
    logic [PCW-1:0]          par_cnt;
    logic                    out_free;
    logic                    accept;

    assign out_free  = ~m_valid | m_ready;
    assign s_ready   = ((fsm == ST_IDLE) || (fsm == ST_DATA)) && out_free;
    assign accept    = s_valid & s_ready;
    assign busy_load = (fsm == ST_LOAD);

    bch_t8_lfsr_step u_step (
        .state      (lfsr),
        .data       (s_data),
        .bank       (bank),
        .next_state (lfsr_next)
    );

`ifdef BCH_BYPASS_EN
    logic bypass_r;
    logic bypass_now;
    // The bypass choice is taken from the port on the first word, then held.
    assign bypass_now = (fsm == ST_IDLE) ? bch_bypass : bypass_r;
`endif

    // NOTE: the row bank is plain flops, not a RAM macro, so it can and does
    // take the asynchronous reset along with the rest of the state.
    always_ff @(posedge clk_1x or negedge rst_n) begin
        if (!rst_n) begin
            fsm        <= ST_LOAD;
            load_cnt   <= '0;
            rom_rd_en  <= 1'b0;
            rom_rdaddr <= '0;
            cap_en     <= 1'b0;
            cap_addr   <= '0;
            bank       <= '0;
            lfsr       <= '0;
            par_cnt    <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
`ifdef BCH_BYPASS_EN
            bypass_r   <= 1'b0;
`endif
        end else begin
            case (fsm)
                ST_LOAD: begin
                    // Reads are issued for ROW_CNT cycles; each row lands one cycle later.
                    load_cnt   <= load_cnt + 5'd1;
                    rom_rd_en  <= (load_cnt < LOAD_ISSUE);
                    rom_rdaddr <= (load_cnt < LOAD_ISSUE) ? load_cnt : 5'd0;
                    cap_en     <= rom_rd_en;
                    cap_addr   <= rom_rdaddr[3:0];
                    if (cap_en) begin
                        bank[cap_addr] <= rom_rd_q;
                    end
                    if (load_cnt == LOAD_DONE) begin
                        fsm      <= ST_IDLE;
                        load_cnt <= '0;
                    end
                end

                ST_IDLE, ST_DATA: begin
                    if (accept) begin
                        m_data  <= s_data;
                        m_valid <= 1'b1;
                        m_last  <= 1'b0;
`ifdef BCH_BYPASS_EN
                        if (fsm == ST_IDLE) begin
                            bypass_r <= bch_bypass;
                        end
                        if (bypass_now) begin
                            m_last <= s_last;
                            fsm    <= s_last ? ST_IDLE : ST_DATA;
                        end else begin
                            lfsr <= lfsr_next;
                            fsm  <= s_last ? ST_PARITY : ST_DATA;
                        end
`else
                        lfsr <= lfsr_next;
                        fsm  <= s_last ? ST_PARITY : ST_DATA;
`endif
                    end else if (out_free) begin
                        m_valid <= 1'b0;
                    end
                end

                ST_PARITY: begin
                    if (out_free) begin
                        m_data  <= lfsr[BCH_PAR_BITS-1 -: BCH_W];
                        lfsr    <= lfsr << BCH_W;
                        m_valid <= 1'b1;
                        if (par_cnt == PAR_LAST) begin
                            m_last  <= 1'b1;
                            par_cnt <= '0;
                            fsm     <= ST_IDLE;
                        end else begin
                            m_last  <= 1'b0;
                            par_cnt <= par_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
